// File: rtl/ssg_scan_decoder.sv
// Recovers the four hex digits shown on a multiplexed seven-segment display by
// sampling its active-low cathode and anode lines and debouncing each scan slot.
module ssg_scan_decoder #(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic        clk,
    input  logic        greset,
    input  logic [7:0]  sseg_cathode,
    input  logic [3:0]  sseg_anode,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic [3:0]  bad_glyph,
    output logic        frame_strobe,
    output logic        anode_err
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_LAST  = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TIMEOUT_MAX  = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

    // Returns {legal, value} for an active-high gfedcba segment pattern.
    function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
        logic [4:0] r;
        case (seg)
            7'h3F:   r = 5'h10;
            7'h06:   r = 5'h11;
            7'h5B:   r = 5'h12;
            7'h4F:   r = 5'h13;
            7'h66:   r = 5'h14;
            7'h6D:   r = 5'h15;
            7'h7D:   r = 5'h16;
            7'h07:   r = 5'h17;
            7'h7F:   r = 5'h18;
            7'h6F:   r = 5'h19;
            7'h77:   r = 5'h1A;
            7'h7C:   r = 5'h1B;
            7'h39:   r = 5'h1C;
            7'h5E:   r = 5'h1D;
            7'h79:   r = 5'h1E;
            7'h71:   r = 5'h1F;
            default: r = 5'h00;
        endcase
        return r;
    endfunction

    function automatic logic single_low(input logic [3:0] an);
        return (an == 4'b1110) || (an == 4'b1101) || (an == 4'b1011) || (an == 4'b0111);
    endfunction

    logic [7:0]    cathode_p0, cathode_p1;
    logic [3:0]    anode_p0, anode_p1;
    state_t        state;
    logic [11:0]   cand;
    logic [SW-1:0] stable_cnt;
    logic [TW-1:0] tmo_cnt [4];
    logic [3:0]    seen;

    logic [11:0]   sample;
    logic          capture;
    logic [4:0]    glyph;
    logic [3:0]    cap_mask;
    logic          multi_err;

    // Stage p0/p1: two-flop synchronizer; idles high like an undriven display.
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            cathode_p0 <= 8'hFF;
            cathode_p1 <= 8'hFF;
            anode_p0   <= 4'hF;
            anode_p1   <= 4'hF;
        end else begin
            cathode_p0 <= sseg_cathode;
            cathode_p1 <= cathode_p0;
            anode_p0   <= sseg_anode;
            anode_p1   <= anode_p0;
        end
    end

    always_comb begin
        sample    = {anode_p1, cathode_p1};
        capture   = (state == SETTLE) && (sample == cand) &&
                    (stable_cnt == STABLE_LAST) && (anode_p1 != 4'hF);
        glyph     = decode_glyph(~cathode_p1[6:0]);
        cap_mask  = (capture && single_low(anode_p1)) ? ~anode_p1 : 4'b0000;
        multi_err = capture && !single_low(anode_p1);
    end

    // Debounce FSM: a capture fires on the edge the count reaches STABLE_CYCLES.
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            state      <= IDLE;
            cand       <= 12'hFFF;
            stable_cnt <= '0;
        end else if (anode_p1 == 4'hF) begin
            state      <= IDLE;
            stable_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    state      <= SETTLE;
                    cand       <= sample;
                    stable_cnt <= SW'(1);
                end
                HELD: begin
                    if (sample != cand) begin
                        state      <= SETTLE;
                        cand       <= sample;
                        stable_cnt <= SW'(1);
                    end
                end
                SETTLE: begin
                    if (sample != cand) begin
                        cand       <= sample;
                        stable_cnt <= SW'(1);
                    end else if (stable_cnt == STABLE_LAST) begin
                        state      <= HELD;
                        stable_cnt <= stable_cnt + SW'(1);
                    end else begin
                        stable_cnt <= stable_cnt + SW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    stable_cnt <= '0;
                end
            endcase
        end
    end

    // Per-digit state; a capture outranks timeout expiry of the same digit.
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            digits      <= 16'h0000;
            dp          <= 4'b0000;
            digit_valid <= 4'b0000;
            bad_glyph   <= 4'b0000;
            anode_err   <= 1'b0;
            for (int n = 0; n < 4; n++) begin
                tmo_cnt[n] <= '0;
            end
        end else begin
            anode_err <= multi_err;
            for (int n = 0; n < 4; n++) begin
                if (cap_mask[n]) begin
                    dp[n]          <= ~cathode_p1[7];
                    bad_glyph[n]   <= ~glyph[4];
                    digit_valid[n] <= glyph[4];
                    tmo_cnt[n]     <= '0;
                    if (glyph[4]) begin
                        digits[4*n +: 4] <= glyph[3:0];
                    end
                end else begin
                    if (tmo_cnt[n] != TIMEOUT_MAX) begin
                        tmo_cnt[n] <= tmo_cnt[n] + TW'(1);
                    end
                    if (tmo_cnt[n] == TIMEOUT_LAST) begin
                        digit_valid[n] <= 1'b0;
                    end
                end
            end
        end
    end

    // Frame tracking: a capture in the clearing cycle starts the next frame.
    always_ff @(posedge clk or negedge greset) begin
        if (!greset) begin
            seen         <= 4'b0000;
            frame_strobe <= 1'b0;
        end else if (seen == 4'hF) begin
            seen         <= cap_mask;
            frame_strobe <= 1'b1;
        end else begin
            seen         <= seen | cap_mask;
            frame_strobe <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ssg_scan_decoder.sv
// Bench for ssg_scan_decoder: directed display scans checked every cycle against
// a run-length model of the sampled display, plus hand-computed spot checks.
module tb_ssg_scan_decoder;
    localparam int     STABLE   = 16;
    localparam longint FAST_TMO = 100;
    localparam longint SLOW_TMO = 1048576;
    localparam logic [6:0] GLYPH [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                          7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    logic        clk = 1'b0;
    logic        greset = 1'b1;
    logic [7:0]  sseg_cathode = 8'hFF;
    logic [3:0]  sseg_anode = 4'hF;

    logic [15:0] digits_s, digits_f;
    logic [3:0]  dp_s, dp_f, valid_s, valid_f, bad_s, bad_f;
    logic        fs_s, fs_f, ae_s, ae_f;
    logic [29:0] pack_s, pack_f;

    assign pack_s = {digits_s, dp_s, valid_s, bad_s, fs_s, ae_s};
    assign pack_f = {digits_f, dp_f, valid_f, bad_f, fs_f, ae_f};

    ssg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(1048576)) u_slow (
        .clk(clk), .greset(greset), .sseg_cathode(sseg_cathode), .sseg_anode(sseg_anode),
        .digits(digits_s), .dp(dp_s), .digit_valid(valid_s), .bad_glyph(bad_s),
        .frame_strobe(fs_s), .anode_err(ae_s));

    ssg_scan_decoder #(.STABLE_CYCLES(STABLE), .TIMEOUT_CYCLES(100)) u_fast (
        .clk(clk), .greset(greset), .sseg_cathode(sseg_cathode), .sseg_anode(sseg_anode),
        .digits(digits_f), .dp(dp_f), .digit_valid(valid_f), .bad_glyph(bad_f),
        .frame_strobe(fs_f), .anode_err(ae_f));

    initial forever #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int fs_cnt = 0;
    int ae_cnt = 0;
    logic saw8 = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Model: the display as seen two edges late; a digit is captured when a
    // non-idle sample has been identical for exactly STABLE consecutive edges.
    logic [11:0] h0, h1, prev;
    int          run;
    longint      cyc;
    logic [3:0]  m_dig [4];
    logic [3:0]  m_dp, m_bad, m_ok, m_seen;
    longint      cap_cyc [4];
    logic        m_frame, m_aerr;

    task automatic model_reset();
        h0 = 12'hFFF; h1 = 12'hFFF; prev = 12'hFFF; run = 0;
        for (int n = 0; n < 4; n++) begin
            m_dig[n] = 4'h0;
            cap_cyc[n] = 0;
        end
        m_dp = 0; m_bad = 0; m_ok = 0; m_seen = 0; m_frame = 0; m_aerr = 0;
    endtask

    task automatic model_step();
        logic [11:0] smp;
        logic [3:0]  capmask;
        int          lows, idx, val;
        logic        found;
        cyc++;
        smp = h1;
        h1 = h0;
        h0 = {sseg_anode, sseg_cathode};
        run = (smp == prev) ? run + 1 : 1;
        prev = smp;
        capmask = 4'b0;
        m_aerr = 1'b0;
        if (smp[11:8] != 4'hF && run == STABLE) begin
            lows = 0; idx = 0;
            for (int n = 0; n < 4; n++) if (!smp[8+n]) begin lows++; idx = n; end
            if (lows == 1) begin
                found = 1'b0; val = 0;
                for (int v = 0; v < 16; v++) if (GLYPH[v] == ~smp[6:0]) begin found = 1'b1; val = v; end
                if (found) m_dig[idx] = 4'(val);
                m_ok[idx] = found;
                m_bad[idx] = ~found;
                m_dp[idx] = ~smp[7];
                cap_cyc[idx] = cyc;
                capmask[idx] = 1'b1;
            end else begin
                m_aerr = 1'b1;
            end
        end
        if (m_seen == 4'hF) begin
            m_frame = 1'b1;
            m_seen = capmask;
        end else begin
            m_frame = 1'b0;
            m_seen = m_seen | capmask;
        end
    endtask

    function automatic logic [29:0] model_out(input longint tmo);
        logic [3:0] v;
        for (int n = 0; n < 4; n++) v[n] = m_ok[n] && ((cyc - cap_cyc[n]) < tmo);
        return {m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp, v, m_bad, m_frame, m_aerr};
    endfunction

    initial begin
        cyc = 0;
        model_reset();
        forever begin
            @(posedge clk or negedge greset);
            if (!greset) model_reset();
            else model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("cycle_slow", 64'(pack_s), 64'(model_out(SLOW_TMO)));
            check("cycle_fast", 64'(pack_f), 64'(model_out(FAST_TMO)));
            if (fs_s) fs_cnt++;
            if (ae_s) ae_cnt++;
            if (digits_s[3:0] == 4'h8) saw8 = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] an, input logic [7:0] cat);
        sseg_anode = an;
        sseg_cathode = cat;
    endtask

    int fs0, ae0;

    initial begin
        #2 greset = 1'b0;
        step(2);
        check("reset_slow", 64'(pack_s), 64'd0);
        check("reset_fast", 64'(pack_f), 64'd0);
        greset = 1'b1;
        step(2);

        // Clean scan 0,1,2,3; the timeout checks count from the last slot's start.
        fs0 = fs_cnt;
        for (int i = 0; i < 4; i++) begin
            drive(4'(~(4'b0001 << i)), ~{1'b0, GLYPH[i]});
            step(40);
        end
        drive(4'hF, 8'hFF);
        step(5);
        check("scan_digits", 64'(digits_s), 64'h3210);
        check("scan_valid", 64'(valid_s), 64'hF);
        check("scan_frames", 64'(fs_cnt - fs0), 64'd1);
        check("model_scan", 64'({m_dig[3], m_dig[2], m_dig[1], m_dig[0]}), 64'h3210);
        step(72);
        check("tmo_before", 64'(valid_f[3]), 64'd1);
        step(1);
        check("tmo_after", 64'(valid_f[3]), 64'd0);
        check("tmo_digit_kept", 64'(digits_f[15:12]), 64'h3);
        check("slow_still_valid", 64'(valid_s[3]), 64'd1);

        // Glitch: a short-lived 8 must never land; 9 lands STABLE+2 edges after it appears.
        drive(4'b1110, ~8'h7F);
        step(10);
        check("glitch_pre", 64'(digits_s[3:0]), 64'h0);
        drive(4'b1110, ~8'h6F);
        step(STABLE + 1);
        check("glitch_early", 64'(digits_s[3:0]), 64'h0);
        step(1);
        check("glitch_capture", 64'(digits_s[3:0]), 64'h9);
        check("model_glitch", 64'(m_dig[0]), 64'h9);
        step(22);
        drive(4'hF, 8'hFF);
        step(5);
        check("glitch_no8", 64'(saw8), 64'd0);

        // All segments dark with the decimal point lit on digit 2.
        drive(4'b1011, 8'h7F);
        step(40);
        drive(4'hF, 8'hFF);
        step(5);
        check("illegal_bad", 64'(bad_s[2]), 64'd1);
        check("illegal_valid", 64'(valid_s[2]), 64'd0);
        check("illegal_dp", 64'(dp_s[2]), 64'd1);
        check("illegal_digit_kept", 64'(digits_s[11:8]), 64'h2);

        // Two anodes low at once.
        fs0 = fs_cnt;
        ae0 = ae_cnt;
        drive(4'b1100, ~8'h3F);
        step(40);
        drive(4'hF, 8'hFF);
        step(5);
        check("ghost_err_pulses", 64'(ae_cnt - ae0), 64'd1);
        check("ghost_digits", 64'(digits_s), 64'h3219);
        check("ghost_no_frame", 64'(fs_cnt - fs0), 64'd0);

        // Reset while digit 1 is settling with its count at 8.
        drive(4'b1101, ~8'h66);
        step(10);
        greset = 1'b0;
        #1;
        check("rst_settle_slow", 64'(pack_s), 64'd0);
        check("rst_settle_fast", 64'(pack_f), 64'd0);
        step(2);
        greset = 1'b1;
        step(STABLE + 1);
        check("rst_no_early_cap", 64'(digits_s), 64'h0000);
        check("rst_no_early_valid", 64'(valid_s), 64'h0);
        step(1);
        check("rst_fresh_cap", 64'(digits_s), 64'h0040);
        check("rst_fresh_valid", 64'(valid_s), 64'h2);
        check("model_rst", 64'(m_dig[1]), 64'h4);
        drive(4'hF, 8'hFF);
        step(5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ssg_scan_decoder.md
SSG_SCAN_DECODER -- requirements
Module: ssg_scan_decoder

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive identical samples required before a digit is accepted (legal range 2..255).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, the maximum number of cycles between refreshes of a digit before that digit is invalidated.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-004 SHALL have port greset, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port sseg_cathode, input, 8 bits: active-low segments; bits 0-6 = a-g, bit 7 = dp; asynchronous to clk.
REQ-006 SHALL have port sseg_anode, input, 4 bits: active-low digit enables; bit n selects digit n; asynchronous to clk.
REQ-007 SHALL have port digits, output, 16 bits: decoded hex values; digit n occupies bits [4n+3:4n].
REQ-008 SHALL have port dp, output, 4 bits: decimal-point state per digit, 1 = lit.
REQ-009 SHALL have port digit_valid, output, 4 bits: 1 = digit n was captured with a legal glyph within TIMEOUT_CYCLES.
REQ-010 SHALL have port bad_glyph, output, 4 bits: 1 = the last capture of digit n held an illegal segment pattern.
REQ-011 SHALL have port frame_strobe, output, 1 bit: one-cycle pulse when all four digits have been captured since the previous pulse.
REQ-012 SHALL have port anode_err, output, 1 bit: one-cycle pulse when a stable anode pattern has more than one bit low.

Function
REQ-013 SHALL pass sseg_cathode and sseg_anode through a two-flop synchronizer; all decisions use the synchronized copies, which adds 2 cycles of input latency.
REQ-014 SHALL run a three-state FSM with states IDLE, SETTLE and HELD.
  - IDLE: anode = 4'b1111.
  - SETTLE: a candidate {anode, cathode} is being counted.
  - HELD: the candidate has been accepted.
REQ-015 SHALL apply these FSM transitions:
  - any state, sample = 4'b1111: go to IDLE.
  - IDLE or HELD, anode not 1111 and sample differs from the held sample: go to SETTLE, load the candidate, set the counter to 1.
  - SETTLE, sample differs from the candidate: reload the candidate and set the counter to 1.
  - SETTLE, counter reaches STABLE_CYCLES: go to HELD and perform the capture in that same cycle.
REQ-016 SHALL, when the captured anode has exactly one low bit n:
  - decode the cathode and write digits[n], dp[n] and bad_glyph[n];
  - set digit_valid[n] = ~bad_glyph[n];
  - reload the timeout counter of digit n;
  - set seen[n].
REQ-017 SHALL, when the captured anode has two or more low bits, pulse anode_err and leave all digit state unchanged.
REQ-018 SHALL decode against this active-high gfedcba table:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
REQ-019 SHALL treat any pattern outside that table as illegal: bad_glyph[n] = 1, digits[n] keeps its previous value, digit_valid[n] = 0.
REQ-020 SHALL pulse frame_strobe in the cycle after seen becomes 4'b1111, and clear seen in that same cycle; a capture landing in the clearing cycle SHALL set its seen bit afresh.
REQ-021 SHALL keep four saturating timeout counters; when counter n reaches TIMEOUT_CYCLES, digit_valid[n] = 0 while digits[n] holds its value.
REQ-022 SHALL give a capture of digit n priority over timeout expiry of digit n in the same cycle.
REQ-023 SHALL never capture a digit twice while it stays HELD; re-capture requires a changed sample or a pass through IDLE.
REQ-024 SHALL use counter widths of clog2(STABLE_CYCLES+1) and clog2(TIMEOUT_CYCLES+1) bits.

Reset
REQ-025 SHALL, while greset = 0, immediately force:
  - FSM = IDLE, all counters = 0, synchronizers = 1, seen = 0;
  - digits = 16'h0000, dp = 0, digit_valid = 0, bad_glyph = 0;
  - frame_strobe = 0, anode_err = 0.
REQ-026 SHALL, when reset is asserted during SETTLE, discard the pending capture; after release the block resumes from IDLE.

Verification
REQ-027 SHALL cover a clean scan: anode 1110/1101/1011/0111, each 40 cycles, cathodes ~3F/~06/~5B/~4F -> digits = 16'h3210, digit_valid = 1111, one frame_strobe.
REQ-028 SHALL cover a glitch: anode 1110 with cathode ~7F held 10 cycles, then ~6F held 40 cycles -> digits[3:0] = 9, captured STABLE_CYCLES+2 cycles after ~6F is applied, and no capture of 8.
REQ-029 SHALL cover an illegal glyph: anode 1011, cathode 8'hFF with dp bit 7 = 0 -> bad_glyph[2] = 1, digit_valid[2] = 0, dp[2] = 1, digits[11:8] unchanged.
REQ-030 SHALL cover a ghosting fault: anode 1100 held 40 cycles -> exactly one anode_err pulse, with digits and seen unchanged.
REQ-031 SHALL cover timeout: with TIMEOUT_CYCLES = 100, a clean scan followed by digit 3 stopped -> digit_valid[3] = 0 after 100 cycles and digits[15:12] retained.
REQ-032 SHALL cover reset during SETTLE: greset = 0 at counter = 8 -> all outputs reset at once, and no capture after release until a fresh STABLE_CYCLES run completes.
